regfile_wb_arbiter: RTL and testbench

//   Producer end of the register file write port (BusW/RW/RegWr). Merges the
//   in-order pipeline writeback (primary, never stalls) with results from

---
 rtl/regfile_wb_arbiter.sv | 120 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the register file: the in-order primary writeback always wins,
// secondary results wait in a small FIFO and drain into idle slots, and pending flags feed the hazard unit.
module regfile_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             Clk,
    input  logic             ResetL,
    input  logic             PriValid,
    input  logic [4:0]       PriRW,
    input  logic [31:0]      PriData,
    input  logic             SecValid,
    output logic             SecReady,
    input  logic [4:0]       SecRW,
    input  logic [31:0]      SecData,
    input  logic [4:0]       RA,
    input  logic [4:0]       RB,
    output logic             PendA,
    output logic             PendB,
    output logic             WawHaz,
    output logic             WawErr,
    output logic             RegWr,
    output logic [4:0]       RW,
    output logic [31:0]      BusW,
    output logic [PTR_W:0]   Count
);

    logic [4:0]       fifo_rw   [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             out_sec;
    logic [31:0]      pending;

    logic sec_live, pri_live, fifo_empty, bypass, enq, deq;

    // Handshake: a secondary item transfers on a posedge where SecValid and SecReady are both
    // high; SecReady depends only on occupancy, never on SecValid or a same-cycle drain.
    assign SecReady   = (count != (PTR_W+1)'(DEPTH));
    assign sec_live   = SecValid & SecReady & (SecRW != 5'd0);
    assign pri_live   = PriValid & (PriRW != 5'd0);
    assign fifo_empty = (count == '0);
    assign bypass     = sec_live & fifo_empty & ~PriValid;
    assign enq        = sec_live & ~bypass;
    assign deq        = ~PriValid & ~fifo_empty;

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // Entry i is live when its distance from head lies below the occupancy.
            if ({1'b0, PTR_W'(PTR_W'(i) - head)} < count)
                pending[fifo_rw[i]] = 1'b1;
        end
        if (RegWr && out_sec)
            pending[RW] = 1'b1;
        pending[0] = 1'b0;
    end

    assign PendA  = pending[RA];
    assign PendB  = pending[RB];
    assign WawHaz = pri_live & pending[PriRW];
    assign Count  = count;

    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            RegWr   <= 1'b0;
            RW      <= '0;
            BusW    <= '0;
            out_sec <= 1'b0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            WawErr  <= 1'b0;
        end else begin
            if (PriValid) begin
                RegWr   <= pri_live;
                out_sec <= 1'b0;
                if (pri_live) begin
                    RW   <= PriRW;
                    BusW <= PriData;
                end
            end else if (deq) begin
                RegWr   <= 1'b1;
                out_sec <= 1'b1;
                RW      <= fifo_rw[head];
                BusW    <= fifo_data[head];
            end else if (bypass) begin
                RegWr   <= 1'b1;
                out_sec <= 1'b1;
                RW      <= SecRW;
                BusW    <= SecData;
            end else begin
                RegWr   <= 1'b0;
                out_sec <= 1'b0;
            end

            if (enq)
                tail <= tail + 1'b1;
            if (deq)
                head <= head + 1'b1;
            if (enq && !deq)
                count <= count + 1'b1;
            else if (deq && !enq)
                count <= count - 1'b1;

            if (WawHaz)
                WawErr <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only observed between head and tail.
    always_ff @(posedge Clk) begin
        if (enq) begin
            fifo_rw[tail]   <= SecRW;
            fifo_data[tail] <= SecData;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: queue-based reference model checked every negedge,
// directed scenarios with literal expectations, then a randomized mix.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk;
    logic             rst_n;
    logic             pri_valid;
    logic [4:0]       pri_rw;
    logic [31:0]      pri_data;
    logic             sec_valid;
    logic             sec_ready;
    logic [4:0]       sec_rw;
    logic [31:0]      sec_data;
    logic [4:0]       ra;
    logic [4:0]       rb;
    logic             pend_a;
    logic             pend_b;
    logic             waw_haz;
    logic             waw_err;
    logic             reg_wr;
    logic [4:0]       rw;
    logic [31:0]      bus_w;
    logic [PTR_W:0]   count;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .Clk(clk), .ResetL(rst_n),
        .PriValid(pri_valid), .PriRW(pri_rw), .PriData(pri_data),
        .SecValid(sec_valid), .SecReady(sec_ready), .SecRW(sec_rw), .SecData(sec_data),
        .RA(ra), .RB(rb), .PendA(pend_a), .PendB(pend_b),
        .WawHaz(waw_haz), .WawErr(waw_err),
        .RegWr(reg_wr), .RW(rw), .BusW(bus_w), .Count(count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]  rw;
        logic [31:0] data;
    } wr_t;

    wr_t         m_q[$];
    bit          m_valid;
    bit          m_sec;
    bit          m_err;
    logic [4:0]  m_rw;
    logic [31:0] m_data;

    function automatic bit m_pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (m_q[i])
            if (m_q[i].rw == r) return 1'b1;
        return m_valid && m_sec && (m_rw == r);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_valid = 1'b0;
            m_sec   = 1'b0;
            m_err   = 1'b0;
            m_rw    = '0;
            m_data  = '0;
        end else begin : model_step
            bit  take;
            bit  used;
            wr_t e;
            take = sec_valid && (m_q.size() < DEPTH);
            used = 1'b0;
            if (pri_valid && pri_rw != 5'd0 && m_pending(pri_rw))
                m_err = 1'b1;
            if (pri_valid) begin
                m_valid = (pri_rw != 5'd0);
                m_sec   = 1'b0;
                if (pri_rw != 5'd0) begin
                    m_rw   = pri_rw;
                    m_data = pri_data;
                end
            end else if (m_q.size() > 0) begin
                e       = m_q.pop_front();
                m_valid = 1'b1;
                m_sec   = 1'b1;
                m_rw    = e.rw;
                m_data  = e.data;
            end else if (take && sec_rw != 5'd0) begin
                m_valid = 1'b1;
                m_sec   = 1'b1;
                m_rw    = sec_rw;
                m_data  = sec_data;
                used    = 1'b1;
            end else begin
                m_valid = 1'b0;
                m_sec   = 1'b0;
            end
            if (take && sec_rw != 5'd0 && !used) begin
                e.rw   = sec_rw;
                e.data = sec_data;
                m_q.push_back(e);
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("regwr", reg_wr, m_valid);
            if (m_valid) begin
                check("rw", rw, m_rw);
                check("busw", bus_w, m_data);
            end
            check("count", count, m_q.size());
            check("secready", sec_ready, m_q.size() != DEPTH);
            check("penda", pend_a, m_pending(ra));
            check("pendb", pend_b, m_pending(rb));
            check("wawhaz", waw_haz, pri_valid && pri_rw != 5'd0 && m_pending(pri_rw));
            check("wawerr", waw_err, m_err);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pri(input logic v, input logic [4:0] r, input logic [31:0] d);
        pri_valid = v;
        pri_rw    = r;
        pri_data  = d;
    endtask

    task automatic set_sec(input logic v, input logic [4:0] r, input logic [31:0] d);
        sec_valid = v;
        sec_rw    = r;
        sec_data  = d;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        bit took;
        rst_n = 1'b1;
        set_pri(1'b0, 5'd0, 32'd0);
        set_sec(1'b0, 5'd0, 32'd0);
        ra = 5'd0;
        rb = 5'd0;
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check("rst_regwr", reg_wr, 1'b0);
        check("rst_rw", rw, 5'd0);
        check("rst_busw", bus_w, 32'd0);
        check("rst_count", count, 3'd0);
        check("rst_secready", sec_ready, 1'b1);
        check("rst_pend", {pend_a, pend_b}, 2'b00);
        tick();
        check("rst_no_pulse", reg_wr, 1'b0);

        // Primary write: latency 1, single pulse
        set_pri(1'b1, 5'd5, 32'h1234);
        tick();
        check("pri_regwr", reg_wr, 1'b1);
        check("pri_rw", rw, 5'd5);
        check("pri_busw", bus_w, 32'h1234);
        set_pri(1'b0, 5'd0, 32'd0);
        tick();
        check("pri_drop", reg_wr, 1'b0);

        // Secondary bypass with pending visible for exactly one cycle
        ra = 5'd7;
        set_sec(1'b1, 5'd7, 32'hAA);
        tick();
        check("byp_regwr", reg_wr, 1'b1);
        check("byp_rw", rw, 5'd7);
        check("byp_busw", bus_w, 32'hAA);
        check("byp_penda", pend_a, 1'b1);
        set_sec(1'b0, 5'd0, 32'd0);
        tick();
        check("byp_done", reg_wr, 1'b0);
        check("byp_penda_clr", pend_a, 1'b0);

        // Fill FIFO behind a continuous primary stream, then drain in order
        for (int i = 1; i <= 4; i++) begin
            set_pri(1'b1, 5'(16 + i), 32'h500 + i);
            set_sec(1'b1, 5'(i), 32'h100 + i);
            tick();
        end
        check("fill_count", count, 3'd4);
        check("model_fill_count", m_q.size(), 4);
        set_sec(1'b1, 5'd5, 32'h105);
        check("fill_secready", sec_ready, 1'b0);
        tick();
        check("full_hold_count", count, 3'd4);
        set_pri(1'b0, 5'd0, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            took = sec_valid && sec_ready;
            tick();
            if (took) set_sec(1'b0, 5'd0, 32'd0);
            check("drain_regwr", reg_wr, 1'b1);
            check("drain_rw", rw, 5'(k));
            check("drain_busw", bus_w, 32'h100 + k);
        end
        check("drain_count", count, 3'd0);

        // R0 writes on both ports are dropped
        set_sec(1'b1, 5'd0, 32'hFF);
        tick();
        check("r0_sec_regwr", reg_wr, 1'b0);
        check("r0_sec_count", count, 3'd0);
        set_sec(1'b0, 5'd0, 32'd0);
        set_pri(1'b1, 5'd0, 32'hFF);
        tick();
        check("r0_pri_regwr", reg_wr, 1'b0);
        check("r0_pri_count", count, 3'd0);

        // WAW hazard and sticky error, then mid-queue reset
        set_pri(1'b1, 5'd3, 32'h33);
        set_sec(1'b1, 5'd9, 32'h99);
        ra = 5'd9;
        tick();
        check("waw_q_count", count, 3'd1);
        check("waw_penda", pend_a, 1'b1);
        set_sec(1'b0, 5'd0, 32'd0);
        set_pri(1'b1, 5'd9, 32'h999);
        #1 check("waw_haz", waw_haz, 1'b1);
        tick();
        check("waw_err", waw_err, 1'b1);
        set_pri(1'b1, 5'd4, 32'h44);
        set_sec(1'b1, 5'd10, 32'hA0);
        tick();
        check("waw_q2_count", count, 3'd2);
        set_pri(1'b0, 5'd0, 32'd0);
        set_sec(1'b0, 5'd0, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_count", count, 3'd0);
        check("mid_rst_wawerr", waw_err, 1'b0);
        check("mid_rst_regwr", reg_wr, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_idle", reg_wr, 1'b0);
        end

        // Randomized mix, checked by the model every cycle
        for (int n = 0; n < 300; n++) begin
            if (!(sec_valid && !sec_ready)) begin
                set_sec($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            end
            set_pri($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
            ra = 5'($urandom_range(0, 7));
            rb = 5'($urandom_range(0, 7));
            tick();
        end
        set_pri(1'b0, 5'd0, 32'd0);
        set_sec(1'b0, 5'd0, 32'd0);
        repeat (6) tick();
        check("final_count", count, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
